rule110_readout: RTL and testbench



---
 rtl/rule110_pkg.sv | 9 +
 rtl/rule110_popcnt.sv | 14 +
 rtl/rule110_readout.sv | 67 ++++++
 tb/tb_rule110_readout.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rule110_pkg.sv
// rule110_pkg: shared sizes and state encoding for the rule-110 readout
package rule110_pkg;
  localparam int WIDTH = 512;
  localparam int WORD = 32;
  localparam int NWORDS = WIDTH / WORD;
  localparam int IDX_W = $clog2(NWORDS);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/rule110_popcnt.sv
// rule110_popcnt: combinational popcount of one output word
module rule110_popcnt #(
  parameter int WORD = 32,
  parameter int CW = $clog2(WORD + 1)
) (
  input  logic [WORD-1:0] word,
  output logic [CW-1:0]   ones
);
  // sum the set bits of the word
  always_comb begin
    ones = '0;
    for (int i = 0; i < WORD; i++) ones = ones + CW'(word[i]);
  end
endmodule

// File: rtl/rule110_readout.sv
// rule110_readout: snapshot the automaton state and stream it out word by word
module rule110_readout
  import rule110_pkg::*;
#(
  parameter int WIDTH = rule110_pkg::WIDTH,
  parameter int WORD = rule110_pkg::WORD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         snap,
  input  logic [WIDTH-1:0]             q_in,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD-1:0]              out_data,
  output logic [$clog2(WIDTH/WORD)-1:0] out_index,
  output logic                         out_last,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic [7:0]                   dropped
);
  localparam int NW = WIDTH / WORD;
  localparam int IW = $clog2(NW);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] shadow;
  logic [IW-1:0] idx;
  logic [CW-1:0] acc, pc;
  logic [WORD-1:0] word;
  logic send, last, hs, cap;
  assign send = state == SEND;
  assign word = shadow[idx*WORD +: WORD];
  assign last = send && idx == IW'(NW - 1);
  assign hs = send && out_ready;
  assign cap = snap && (!send || (hs && last));
  assign busy = send;
  assign out_valid = send;
  assign out_data = send ? word : '0;
  assign out_index = send ? idx : '0;
  assign out_last = last;
  assign out_ones = last ? acc + pc : '0;
  rule110_popcnt #(.WORD(WORD), .CW(CW)) u_popcnt (.word(word), .ones(pc));
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // a capture always lands in SEND; the last handshake without one ends the stream
  always_comb begin
    state_n = cap ? SEND : (hs && last) ? IDLE : state;
  end
  // shadow capture, word index and running live-cell count
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      acc <= '0;
    end else if (cap) begin
      shadow <= q_in;
      idx <= '0;
      acc <= '0;
    end else if (hs) begin
      idx <= last ? '0 : idx + IW'(1);
      acc <= last ? '0 : acc + pc;
    end
  end
  // count snap requests that arrive while a snapshot is still in flight
  always_ff @(posedge clk) begin
    if (reset) dropped <= '0;
    else if (snap && send && !(hs && last) && dropped != 8'hFF) dropped <= dropped + 8'd1;
  end
endmodule

// File: tb/tb_rule110_readout.sv
// tb_rule110_readout: scoreboard bench for the rule-110 snapshot reader
module tb_rule110_readout;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
    logic [9:0]  o;
  } exp_t;
  logic clk = 1'b0;
  logic reset, snap, out_ready;
  logic [511:0] q_in;
  logic busy, out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0] out_index;
  logic [9:0] out_ones;
  logic [7:0] dropped;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic stalled = 1'b0;
  logic [31:0] hold_d;
  logic [3:0] hold_i;
  rule110_readout dut (
    .clk(clk), .reset(reset), .snap(snap), .q_in(q_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_ones(out_ones), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic push_snap(input logic [511:0] v);
    int s = 0;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.d = v[i*32 +: 32];
      s += $countones(e.d);
      e.i = 4'(i);
      e.l = (i == 15);
      e.o = (i == 15) ? 10'(s) : 10'd0;
      sb.push_back(e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb.size() > 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(sb.size()), 0);
  endtask
  // pop and compare every accepted word; verify words hold while stalled
  always @(negedge clk) begin
    exp_t e;
    if (reset) stalled = 1'b0;
    else begin
      if (stalled && out_valid) begin
        check("stall_data", 64'(out_data), 64'(hold_d));
        check("stall_index", 64'(out_index), 64'(hold_i));
      end
      if (out_valid && out_ready) begin
        check("extra_word", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("data", 64'(out_data), 64'(e.d));
          check("index", 64'(out_index), 64'(e.i));
          check("last", 64'(out_last), 64'(e.l));
          check("ones", 64'(out_ones), 64'(e.o));
        end
      end
      stalled = out_valid && !out_ready;
      hold_d = out_data;
      hold_i = out_index;
    end
  end
  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [511:0] v;
    logic [511:0] w;
    int n;
    reset = 1'b1; snap = 1'b0; out_ready = 1'b0; q_in = '0;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_data", 64'(out_data), 0);
    check("rst_last", 64'(out_last), 0);
    check("rst_ones", 64'(out_ones), 0);
    check("rst_dropped", 64'(dropped), 0);
    reset = 1'b0;
    // single-cell seed, 16-cycle stream
    q_in = 512'h1; out_ready = 1'b1; snap = 1'b1; push_snap(q_in);
    tick();
    snap = 1'b0;
    check("seed_busy", 64'(busy), 1);
    check("seed_index0", 64'(out_index), 0);
    repeat (15) tick();
    check("seed_last15", 64'(out_last), 1);
    tick();
    check("seed_done_busy", 64'(busy), 0);
    check("seed_done_valid", 64'(out_valid), 0);
    check("seed_drained", 64'(sb.size()), 0);
    // backpressure with pseudo-random ready
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'hA5A50000 | 32'(i);
    q_in = v; push_snap(v); snap = 1'b1;
    tick();
    snap = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("bp_drained", 64'(sb.size()), 0);
    check("bp_idle", 64'(busy), 0);
    // overrun: three ignored snaps, then q_in changes under the stream
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    q_in = v; push_snap(v); snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      snap = 1'b1;
      tick();
      snap = 1'b0;
    end
    q_in = ~v;
    wait_drain(40);
    check("overrun_dropped", 64'(dropped), 3);
    // back-to-back capture on the last handshake
    tick();
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    q_in = v; push_snap(v); snap = 1'b1;
    tick();
    snap = 1'b0;
    repeat (15) tick();
    check("b2b_last", 64'(out_last), 1);
    q_in = w; push_snap(w); snap = 1'b1;
    tick();
    snap = 1'b0;
    check("b2b_valid", 64'(out_valid), 1);
    check("b2b_index", 64'(out_index), 0);
    check("b2b_dropped", 64'(dropped), 3);
    // reset at index 7 aborts the stream
    n = 0;
    while (out_index != 4'd7 && n < 20) begin
      tick();
      n++;
    end
    check("mid_index7", 64'(out_index), 7);
    reset = 1'b1;
    tick();
    sb.delete();
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_data", 64'(out_data), 0);
    check("mid_rst_index", 64'(out_index), 0);
    check("mid_rst_ones", 64'(out_ones), 0);
    check("mid_rst_dropped", 64'(dropped), 0);
    reset = 1'b0;
    // all-ones restart after reset
    out_ready = 1'b0;
    q_in = '1; push_snap(q_in); snap = 1'b1;
    tick();
    snap = 1'b0;
    check("ones_valid", 64'(out_valid), 1);
    check("ones_index0", 64'(out_index), 0);
    check("ones_data0", 64'(out_data), 64'hFFFFFFFF);
    out_ready = 1'b1;
    wait_drain(40);
    check("ones_idle", 64'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
